// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per start, byte strobes,
// lane-replicated store data, sign/zero-extended load results.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of issuing them.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        op_code,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  load_store_unit_if.master mem
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]      ld_q, ld_d;
  logic             req_q, req_d, we_q, we_d;
  logic [31:0]      maddr_q, maddr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;

  logic             is_load, is_store, legal, misalign;
  logic [31:0]      wdata_c;
  logic [3:0]       wstrb_c;
  logic [15:0]      rot_c;
  logic [31:0]      ext_c;

  // Decode legality of the incoming access
  always_comb begin
    is_load  = (op_code == OP_LOAD);
    is_store = (op_code == OP_STORE);
    legal    = (is_load  && (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd2 ||
                             funct3 == 3'd4 || funct3 == 3'd5)) ||
               (is_store && (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd2));
`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'd1:    misalign = addr[0];
      2'd2:    misalign = (addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  // Store lane replication and byte strobes; bits shifted past lane 3 drop off
  always_comb begin
    case (funct3[1:0])
      2'd0: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = 4'b0011 << addr[1:0];
      end
      default: begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
      end
    endcase
  end

  // Load extraction: rotate so the addressed lane lands at bit 0 (halfword at
  // offset 3 wraps its upper byte from lane 0)
  always_comb begin
    rot_c = 16'({mem.mem_rdata, mem.mem_rdata} >> {off_q, 3'b000});
    case (f3_q)
      3'd0:    ext_c = {{24{rot_c[7]}}, rot_c[7:0]};
      3'd1:    ext_c = {{16{rot_c[15]}}, rot_c[15:0]};
      3'd4:    ext_c = {24'd0, rot_c[7:0]};
      3'd5:    ext_c = {16'd0, rot_c[15:0]};
      default: ext_c = mem.mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ld_d      = ld_q;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    f3_d      = f3_q;
    off_d     = off_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = is_load;
          f3_d      = funct3;
          off_d     = addr[1:0];
          busy_d    = 1'b1;
          if (legal && !misalign) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store;
            maddr_d = {addr[31:2], 2'b00};
            cnt_d   = '0;
            if (is_store) begin
              wdata_d = wdata_c;
              wstrb_d = wstrb_c;
            end else begin
              wstrb_d = 4'b0000;
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          if (is_load_q) ld_d = ext_c;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        wstrb_d = 4'b0000;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ld_q      <= ld_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign load_data     = ld_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: instance a (default timeout) and instance b
// (ACK_TIMEOUT=4); expected completions are queued at start and matched on done.
module tb_load_store_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] addr, sd;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [31:0] ld_a, ld_b;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  typedef struct { int cyc; logic err; logic [31:0] ld; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  load_store_unit_if bus_a();
  load_store_unit_if bus_b();

  load_store_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op_code(op), .funct3(f3),
    .addr(addr), .store_data(sd), .busy(busy_a), .done(done_a), .err(err_a),
    .load_data(ld_a), .mem(bus_a)
  );

  load_store_unit #(.ACK_TIMEOUT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op_code(op), .funct3(f3),
    .addr(addr), .store_data(sd), .busy(busy_b), .done(done_b), .err(err_b),
    .load_data(ld_b), .mem(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (q_a.size() == 0) check("a_spurious_done", 32'(done_a), 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_done_cycle", 32'(cyc), 32'(e.cyc));
        check("a_err", 32'(err_a), 32'(e.err));
        check("a_load_data", ld_a, e.ld);
      end
    end
    if (rst_n && done_b) begin
      if (q_b.size() == 0) check("b_spurious_done", 32'(done_b), 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_done_cycle", 32'(cyc), 32'(e.cyc));
        check("b_err", 32'(err_b), 32'(e.err));
        check("b_load_data", ld_b, e.ld);
      end
    end
  end

  // One transaction: start in cycle 0, ack in cycle ack_k (-1 none), done
  // expected in cycle done_k; optional stray start at cycle restart_k
  task automatic txn(input bit sel, input logic [6:0] o, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     input int ack_k, input logic [31:0] rd, input int done_k,
                     input logic exp_err, input logic [31:0] exp_ld,
                     input logic exp_we, input logic [31:0] exp_wd,
                     input logic [3:0] exp_strb, input int restart_k);
    exp_t e;
    logic b_busy, b_req, b_we;
    logic [31:0] b_addr, b_wd;
    logic [3:0] b_strb;
    @(negedge clk);
    op = o; f3 = f; addr = a; sd = d;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    e.cyc = cyc + done_k; e.err = exp_err; e.ld = exp_ld;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      op = 7'h7f; f3 = 3'd7; addr = 32'hffff_ffff; sd = 32'h5a5a_5a5a;
      if (k == restart_k) begin
        op = LD; f3 = 3'd2; addr = 32'h0000_0800;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      b_busy = sel ? busy_b : busy_a;
      b_req  = sel ? bus_b.mem_req : bus_a.mem_req;
      b_we   = sel ? bus_b.mem_we : bus_a.mem_we;
      b_addr = sel ? bus_b.mem_addr : bus_a.mem_addr;
      b_wd   = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
      b_strb = sel ? bus_b.mem_wstrb : bus_a.mem_wstrb;
      check("busy_active", 32'(b_busy), 32'd1);
      if (k < done_k) begin
        check("mem_req", 32'(b_req), 32'd1);
        check("mem_addr", b_addr, {a[31:2], 2'b00});
        check("mem_we", 32'(b_we), 32'(exp_we));
        check("mem_wstrb", 32'(b_strb), 32'(exp_strb));
        if (exp_we) check("mem_wdata", b_wd, exp_wd);
      end else begin
        check("mem_req_low_in_done", 32'(b_req), 32'd0);
      end
      if (sel) begin bus_b.mem_ack = (k == ack_k); bus_b.mem_rdata = rd; end
      else     begin bus_a.mem_ack = (k == ack_k); bus_a.mem_rdata = rd; end
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    bus_a.mem_ack = 1'b0; bus_b.mem_ack = 1'b0;
    check("idle_after_done", 32'(sel ? busy_b : busy_a), 32'd0);
    check("done_consumed", 32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld_exp;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    op = '0; f3 = '0; addr = '0; sd = '0;
    bus_a.mem_ack = 1'b0; bus_a.mem_rdata = '0;
    bus_b.mem_ack = 1'b0; bus_b.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_load_data", ld_a, 32'd0);
    check("rst_mem_req", 32'(bus_a.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus_a.mem_we), 32'd0);
    check("rst_mem_addr", bus_a.mem_addr, 32'd0);
    check("rst_mem_wdata", bus_a.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus_a.mem_wstrb), 32'd0);
    rst_n = 1'b1;

    // Loads with various sizes and offsets
    txn(0, LD, 3'd2, 32'h100, 32'h0, 1, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 0, 0, 4'h0, 0);
    txn(0, LD, 3'd0, 32'h103, 32'h0, 1, 32'h80112233, 2, 0, 32'hFFFFFF80, 0, 0, 4'h0, 0);
    txn(0, LD, 3'd4, 32'h103, 32'h0, 1, 32'h80112233, 2, 0, 32'h00000080, 0, 0, 4'h0, 0);
    txn(0, LD, 3'd5, 32'h102, 32'h0, 1, 32'h80112233, 2, 0, 32'h00008011, 0, 0, 4'h0, 0);
    txn(0, LD, 3'd1, 32'h102, 32'h0, 1, 32'h80112233, 2, 0, 32'hFFFF8011, 0, 0, 4'h0, 0);
    ld_exp = 32'hFFFF8011;

    // Stores
    txn(0, ST, 3'd0, 32'h205, 32'h123456AB, 2, 32'h0, 3, 0, ld_exp, 1, 32'hABABABAB, 4'b0010, 0);
    txn(0, ST, 3'd1, 32'h206, 32'h0000BEEF, 1, 32'h0, 2, 0, ld_exp, 1, 32'hBEEFBEEF, 4'b1100, 0);
    txn(0, ST, 3'd2, 32'h300, 32'hCAFEBABE, 1, 32'h0, 2, 0, ld_exp, 1, 32'hCAFEBABE, 4'b1111, 0);

    // Ack outside REQ is ignored
    @(negedge clk);
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 32'h99999999;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    check("idle_ack_busy", 32'(busy_a), 32'd0);
    check("idle_ack_load_data", ld_a, ld_exp);

    // Delayed ack with a stray start while busy
    txn(0, LD, 3'd2, 32'h400, 32'h0, 5, 32'h01234567, 6, 0, 32'h01234567, 0, 0, 4'h0, 3);
    ld_exp = 32'h01234567;

    // Illegal accesses
    txn(0, LD, 3'd3, 32'h100, 32'h0, -1, 32'h0, 1, 1, ld_exp, 0, 0, 4'h0, 0);
    txn(0, 7'h33, 3'd0, 32'h100, 32'h0, -1, 32'h0, 1, 1, ld_exp, 0, 0, 4'h0, 0);
    txn(0, ST, 3'd4, 32'h100, 32'h0, -1, 32'h0, 1, 1, ld_exp, 0, 0, 4'h0, 0);

    // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
    txn(0, LD, 3'd2, 32'h102, 32'h0, -1, 32'h0BADF00D, 1, 1, ld_exp, 0, 0, 4'h0, 0);
    txn(0, ST, 3'd1, 32'h103, 32'hAAAA1234, -1, 32'h0, 1, 1, ld_exp, 0, 0, 4'h0, 0);
    txn(0, LD, 3'd1, 32'h103, 32'h0, -1, 32'h80AABBF1, 1, 1, ld_exp, 0, 0, 4'h0, 0);
`else
    txn(0, LD, 3'd2, 32'h102, 32'h0, 1, 32'h0BADF00D, 2, 0, 32'h0BADF00D, 0, 0, 4'h0, 0);
    txn(0, ST, 3'd1, 32'h103, 32'hAAAA1234, 1, 32'h0, 2, 0, 32'h0BADF00D, 1, 32'h12341234, 4'b1000, 0);
    txn(0, LD, 3'd1, 32'h103, 32'h0, 1, 32'h80AABBF1, 2, 0, 32'hFFFFF180, 0, 0, 4'h0, 0);
`endif

    // Timeout instance: normal load, expiry, and ack on the expiry cycle
    txn(1, LD, 3'd2, 32'h040, 32'h0, 1, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 0, 0, 4'h0, 0);
    txn(1, LD, 3'd2, 32'h044, 32'h0, -1, 32'h11111111, 5, 1, 32'hCAFEF00D, 0, 0, 4'h0, 0);
    txn(1, LD, 3'd2, 32'h048, 32'h0, 4, 32'h13579BDF, 5, 0, 32'h13579BDF, 0, 0, 4'h0, 0);

    // Reset mid-transaction drops the request at once and issues no done
    @(negedge clk);
    op = LD; f3 = 3'd2; addr = 32'h500; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("midrst_req_before", 32'(bus_a.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_async", 32'(bus_a.mem_req), 32'd0);
    check("midrst_busy_async", 32'(busy_a), 32'd0);
    check("midrst_load_data", ld_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(q_a.size() + q_b.size()), 32'd0);
    check("midrst_idle", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
